// File: rtl/serial_master_port.sv
// serial_master_port -- master endpoint of the bit-serial slave bus.
//
// A parallel request sampled in IDLE becomes a control frame shifted out on
// `control`: 1,1,1, slave_id MSB-first, rw, burst, then address MSB-first.
// The data phase follows. Write words go out MSB-first on `wD`. Read words
// are assembled from `rD`, and the first bit received becomes the MSB. In the
// data phase a bit moves only on an edge where valid && ready.
//
// Ports:
//   clk, rstN           clock (rising edge), asynchronous active-low reset
//   start               request pulse, sampled only in IDLE
//   slave_id, rw, burst,
//   address, burst_len  request fields; burst_len=0 counts as one word
//   wr_data             next write word
//   wr_data_ack         registered pulse: wr_data was consumed
//   rd_data             last completed read word
//   rd_data_valid       registered pulse: rd_data updated
//   busy                state is not IDLE
//   done                registered pulse at transaction end
//   control             serial control frame, idles low
//   wD, valid, last     serial write data, data-bit strobe, final-word flag
//   rD, ready           serial read data, slave accept/present strobe
module serial_master_port #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int SLAVE_ID_WIDTH = 2,
  parameter int BURST_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      start,
  input  logic [SLAVE_ID_WIDTH-1:0] slave_id,
  input  logic                      rw,
  input  logic                      burst,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [BURST_WIDTH-1:0]    burst_len,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_data_ack,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_data_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      control,
  output logic                      wD,
  output logic                      valid,
  output logic                      last,
  input  logic                      rD,
  input  logic                      ready
);

  localparam int FRAME_W = 3 + SLAVE_ID_WIDTH + 2 + ADDR_WIDTH;
  localparam int FCW     = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int BCW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;

  state_t                  state, state_nxt;
  logic [FRAME_W-1:0]      frame_sr;
  logic [FCW-1:0]          frame_cnt;
  logic [DATA_WIDTH-1:0]   tx_sr;
  logic [DATA_WIDTH-2:0]   rx_sr;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [BCW-1:0]          bit_cnt;
  logic [BURST_WIDTH-1:0]  words_left;
  logic                    rw_q;
  logic                    xfer;
  logic                    frame_end;
  logic                    word_end;
  logic                    final_word;

  assign xfer       = (state == DATA) && ready;
  assign frame_end  = (state == CTRL) && (frame_cnt == FCW'(FRAME_W - 1));
  assign word_end   = xfer && (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign final_word = (words_left == BURST_WIDTH'(1));
  // Word as it stands once the bit currently on rD is shifted in.
  assign rx_word    = {rx_sr, rD};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;
    control   = 1'b0;
    wD        = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CTRL;
      CTRL: begin
        busy    = 1'b1;
        control = frame_sr[FRAME_W-1];
        if (frame_end) state_nxt = DATA;
      end
      DATA: begin
        busy  = 1'b1;
        valid = 1'b1;
        last  = final_word;
        wD    = rw_q & tx_sr[DATA_WIDTH-1];
        if (word_end && final_word) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frame_sr      <= '0;
      frame_cnt     <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      bit_cnt       <= '0;
      words_left    <= '0;
      rw_q          <= 1'b0;
      rd_data       <= '0;
      wr_data_ack   <= 1'b0;
      rd_data_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      wr_data_ack   <= 1'b0;
      rd_data_valid <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: if (start) begin
          frame_sr   <= {3'b111, slave_id, rw, burst, address};
          frame_cnt  <= '0;
          bit_cnt    <= '0;
          rw_q       <= rw;
          words_left <= (burst && (burst_len != '0)) ? burst_len : BURST_WIDTH'(1);
        end
        CTRL: begin
          frame_sr  <= {frame_sr[FRAME_W-2:0], 1'b0};
          frame_cnt <= frame_cnt + 1'b1;
          // The first write word is fetched on the edge that closes the frame,
          // so its MSB is on wD in the first data cycle.
          if (frame_end && rw_q) begin
            tx_sr       <= wr_data;
            wr_data_ack <= 1'b1;
          end
        end
        DATA: if (xfer) begin
          bit_cnt <= bit_cnt + 1'b1;
          tx_sr   <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
          rx_sr   <= rx_word[DATA_WIDTH-2:0];
          if (word_end) begin
            bit_cnt <= '0;
            if (!rw_q) begin
              rd_data       <= rx_word;
              rd_data_valid <= 1'b1;
            end
            if (final_word) begin
              done <= 1'b1;
            end else begin
              words_left <= words_left - 1'b1;
              // Back-to-back reload keeps the bit stream free of gap cycles.
              if (rw_q) begin
                tx_sr       <= wr_data;
                wr_data_ack <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_master_port.sv
module tb_serial_master_port;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int SW = 2;
  localparam int BW = 8;
  localparam int FR = 3 + SW + 2 + AW;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic [SW-1:0] slave_id;
  logic          rw;
  logic          burst;
  logic [AW-1:0] address;
  logic [BW-1:0] burst_len;
  logic [DW-1:0] wr_data;
  logic          wr_data_ack;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          busy;
  logic          done;
  logic          control;
  logic          wD;
  logic          valid;
  logic          last;
  logic          rD;
  logic          ready;

  always #5 clk = ~clk;

  serial_master_port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVE_ID_WIDTH(SW), .BURST_WIDTH(BW)
  ) dut (
    .clk(clk), .rstN(rstN), .start(start), .slave_id(slave_id), .rw(rw),
    .burst(burst), .address(address), .burst_len(burst_len), .wr_data(wr_data),
    .wr_data_ack(wr_data_ack), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .busy(busy), .done(done), .control(control), .wD(wD), .valid(valid),
    .last(last), .rD(rD), .ready(ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_control"}, control, 1'b0);
    chk({tag, "_wD"}, wD, 1'b0);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_last"}, last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ack"}, wr_data_ack, 1'b0);
    chk({tag, "_rdv"}, rd_data_valid, 1'b0);
  endtask

  // One transaction against the model: expected frame from the request
  // fields, expected serial stream from the word queues, latency from
  // frame length, word count and the number of stalled data cycles.
  task automatic run_txn(input logic [SW-1:0] sid, input logic rw_i, input logic burst_i,
                         input logic [AW-1:0] addr, input logic [BW-1:0] blen,
                         input int stall_pct, input int stall_at, input int stall_len,
                         input bit poke, output int done_c, output logic [FR-1:0] ctrl_seen);
    int nw, k, c, stalls, fstall, acks, rvs;
    bit fin, in_data;
    logic rdy;
    logic [FR-1:0] frame;
    nw = burst_i ? ((blen == 0) ? 1 : int'(blen)) : 1;
    while (wq.size() < nw) wq.push_back(DW'($urandom));
    while (rq.size() < nw) rq.push_back(DW'($urandom));
    frame = {3'b111, sid, rw_i, burst_i, addr};
    ctrl_seen = '0;
    k = 0; c = 0; stalls = 0; fstall = 0; acks = 0; rvs = 0; fin = 0; done_c = -1;
    @(negedge clk);
    slave_id = sid; rw = rw_i; burst = burst_i; address = addr; burst_len = blen;
    wr_data = wq[0]; start = 1'b1; ready = 1'b1; rD = 1'b0;
    while (!fin && c < FR + nw * DW * 4 + 200) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (poke && c == 5) begin
        start = 1'b1;
        slave_id = SW'($urandom); rw = 1'($urandom); burst = 1'($urandom);
        address = AW'($urandom); burst_len = BW'($urandom);
      end
      if (c <= FR) begin
        ctrl_seen[FR-c] = control;
        chk("frame_valid", valid, 1'b0);
        chk("frame_busy", busy, 1'b1);
        chk("frame_done", done, 1'b0);
        if (c == FR) chk("frame_bits", ctrl_seen, frame);
      end else if (done) begin
        fin = 1;
        done_c = c;
        chk("done_bits", k, nw * DW);
        chk("done_cycle", c, FR + nw * DW + stalls + 1);
        chk("done_busy", busy, 1'b0);
        chk("done_valid", valid, 1'b0);
        chk("done_last", last, 1'b0);
      end else if (k >= nw * DW) begin
        chk("done_when_due", done, 1'b1);
        fin = 1;
      end else begin
        chk("data_valid", valid, 1'b1);
        chk("data_busy", busy, 1'b1);
        chk("data_control", control, 1'b0);
        chk("data_last", last, (k >= (nw - 1) * DW));
        if (rw_i) chk("data_wD", wD, wq[k/DW][DW-1-(k%DW)]);
      end
      if (wr_data_ack) begin
        acks++;
        wr_data = (acks < nw) ? wq[acks] : DW'($urandom);
      end
      if (rd_data_valid) begin
        if (rvs < nw) chk("rd_word", rd_data, rq[rvs]);
        chk("rd_align", k, (rvs + 1) * DW);
        rvs++;
      end
      in_data = (c >= FR) && !fin;
      rdy = 1'b1;
      if (in_data && c > FR - 1) begin
        if (c > FR && k >= stall_at && fstall < stall_len) begin
          rdy = 1'b0;
          fstall++;
        end else if (c > FR && $urandom_range(99) < stall_pct) begin
          rdy = 1'b0;
        end
      end
      ready = rdy;
      rD = (k < nw * DW) ? rq[k/DW][DW-1-(k%DW)] : 1'($urandom);
      if (c > FR && !fin) begin
        if (rdy) k++;
        else stalls++;
      end
    end
    if (!fin) chk("txn_timeout", 32'd0, 32'd1);
    chk("ack_count", acks, rw_i ? nw : 0);
    chk("rdv_count", rvs, rw_i ? 0 : nw);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", valid, 1'b0);
    chk("idle_control", control, 1'b0);
    chk("idle_done", done, 1'b0);
    ready = 1'b0;
    wq.delete();
    rq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    logic [FR-1:0] cs;
    rstN = 1'b0; start = 1'b0; slave_id = '0; rw = 1'b0; burst = 1'b0;
    address = '0; burst_len = '0; wr_data = '0; rD = 1'b0; ready = 1'b0;

    // 1: reset hold then release
    repeat (3) @(negedge clk);
    chk_quiet_outputs("rst");
    chk("rst_rd_data", rd_data, 8'h00);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    chk_quiet_outputs("post_rst");

    // 2: single write
    wq.push_back(8'hC3);
    run_txn(2'd1, 1'b1, 1'b0, 12'h0A5, 8'd0, 0, 0, 0, 1'b0, dc, cs);
    chk("t2_frame", cs, 19'b1110110000010100101);
    chk("t2_done_cycle", dc, 28);

    // 3: burst read of three words
    rq.push_back(8'h5A); rq.push_back(8'hFF); rq.push_back(8'h01);
    run_txn(2'd2, 1'b0, 1'b1, 12'h3C1, 8'd3, 0, 0, 0, 1'b0, dc, cs);
    chk("t3_done_cycle", dc, 1 + FR + 3 * DW);
    chk("t3_last_word", rd_data, 8'h01);

    // 4: write with a 4-cycle stall mid-word
    wq.push_back(8'h96);
    run_txn(2'd3, 1'b1, 1'b0, 12'h777, 8'd0, 0, 3, 4, 1'b0, dc, cs);
    chk("t4_done_cycle", dc, 28 + 4);

    // 5: burst_len=0 gives one word; start during busy ignored; next txn normal
    run_txn(2'd0, 1'b1, 1'b1, 12'h123, 8'd0, 0, 0, 0, 1'b1, dc, cs);
    chk("t5_done_cycle", dc, 28);
    rq.push_back(8'hA7);
    run_txn(2'd1, 1'b0, 1'b0, 12'hFED, 8'd9, 0, 0, 0, 1'b0, dc, cs);
    chk("t5b_rd_data", rd_data, 8'hA7);

    // 6: reset at frame bit 10
    @(negedge clk);
    slave_id = 2'd2; rw = 1'b1; burst = 1'b0; address = 12'h555; wr_data = 8'h3C; start = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t6_pre_busy", busy, 1'b1);
    #2 rstN = 1'b0;
    #1;
    chk_quiet_outputs("t6_async");
    chk("t6_rd_data", rd_data, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", done, 1'b0);
      chk("t6_idle", busy, 1'b0);
    end
    rstN = 1'b1;
    run_txn(2'd2, 1'b1, 1'b0, 12'h555, 8'd0, 0, 0, 0, 1'b0, dc, cs);
    chk("t6_done_cycle", dc, 28);

    // randomized transactions with random stalls
    for (int n = 0; n < 12; n++) begin
      run_txn(SW'($urandom), 1'($urandom), 1'($urandom), AW'($urandom),
              BW'($urandom_range(0, 4)), 25, 0, 0, 1'($urandom), dc, cs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_master_port.md
Name: serial_master_port

Overview:
Master-side endpoint of the bit-serial slave bus. It accepts a parallel transaction request and serializes the control frame onto `control`. It then streams write words out on `wD`, or collects read words from `rD`, using a per-bit valid/ready handshake. One instance per bus master; it pairs with the UART slave system on the far end of the link.

Parameters:
- DATA_WIDTH, 8, bits per data word.
- ADDR_WIDTH, 12, start-address bits in the control frame.
- SLAVE_ID_WIDTH, 2, slave-id bits in the control frame.
- BURST_WIDTH, 8, width of the burst word-count input.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstN  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- slave_id  in  SLAVE_ID_WIDTH  target slave.
- rw  in  1  1 = write, 0 = read.
- burst  in  1  1 = burst, 0 = single word.
- address  in  ADDR_WIDTH  start address.
- burst_len  in  BURST_WIDTH  word count when burst=1.
- wr_data  in  DATA_WIDTH  next write word.
- wr_data_ack  out  1  pulse: wr_data was consumed this cycle.
- rd_data  out  DATA_WIDTH  last completed read word.
- rd_data_valid  out  1  pulse: rd_data updated.
- busy  out  1  high while the state is not IDLE.
- done  out  1  pulse at transaction end.
- control  out  1  serial control frame; idles 0.
- wD  out  1  serial write data.
- valid  out  1  master data-bit strobe.
- last  out  1  high during the bits of the final word.
- rD  in  1  serial read data from the slave.
- ready  in  1  slave accept/present strobe.

Behaviour:
- Reset (async, rstN=0):
  - State goes to IDLE.
  - All outputs are 0; rd_data is 0.
  - Counters and shift registers clear.
  - Reset mid-transaction aborts immediately. No done pulse is produced.
- States: IDLE, CTRL, DATA.
- IDLE:
  - On start=1, latch slave_id, rw, burst, address.
  - Latch the word count: burst ? max(burst_len,1) : 1. burst_len=0 is treated as 1.
  - Go to CTRL. busy=1 from the next cycle.
- CTRL:
  - Frame is 3+SLAVE_ID_WIDTH+2+ADDR_WIDTH bits (19 with defaults), one bit per cycle, no handshake.
  - Frame order: 1,1,1, then slave_id MSB-first, then rw, then burst, then address MSB-first.
  - The first frame bit appears the cycle after start is sampled.
  - After the final frame bit, control=0 and the state goes to DATA.
  - On a write, the same edge loads wr_data into the TX shift register and pulses wr_data_ack.
- DATA:
  - valid=1 continuously.
  - A bit transfers only on an edge where valid&&ready. ready=0 stalls the transfer; bit and word counters hold.
  - Write: wD = TX shift MSB, shifting left on each transfer.
  - Read: rD is shifted into the RX register LSB-side on each transfer, so the first bit ends up as the MSB.
  - last=1 throughout all bits of the final word.
  - Word boundary (DATA_WIDTH transfers, non-final word):
    - Write: reload from wr_data and pulse wr_data_ack on the same edge. There are no gap cycles.
    - Read: rd_data <= assembled word and pulse rd_data_valid.
  - Final word's last transfer:
    - Read: rd_data/rd_data_valid update as above.
    - Pulse done and go to IDLE on the same edge.
    - valid, last, and busy are 0 the next cycle.
- wr_data_ack timing: one-cycle registered pulse. The user must present the next word by the following cycle.
- start while busy is ignored. Request inputs are don't-care outside the IDLE sample.
- Transaction latency without stalls: 1 + frame + words*DATA_WIDTH cycles from start to done (default single word: 1+19+8 = 28 cycles).

Test Plan:
1. Reset hold, then release:
   - control, wD, valid, last, busy, done, rd_data_valid all 0.
   - rd_data = 0.
2. Single write, slave_id=1, address=0x0A5, wr_data=0xC3, ready=1:
   - control stream is 111_01_1_0_000010100101.
   - wD sequence is 11000011 with valid=1 and last=1 for 8 cycles.
   - wr_data_ack pulses once; done pulses at cycle 28.
3. Burst read, slave_id=2, burst_len=3, rD supplying 0x5A, 0xFF, 0x01:
   - rd_data_valid pulses 3 times with those values in order.
   - last is high only during the third word's bits.
4. Write with ready toggled low for 4 cycles mid-word:
   - wD and the bit counter hold during the stall.
   - The transmitted word is intact; done is delayed by exactly 4 cycles.
5. burst=1, burst_len=0:
   - Exactly one word is transferred.
   - A start pulse during busy is ignored.
   - A second transaction after done proceeds normally.
6. Assert rstN=0 at frame bit 10:
   - Outputs go to 0 immediately; no done pulse.
   - A fresh start then produces a complete frame.
